// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count, programmable almost flags, flush and sticky error flags.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads; otherwise out updates one cycle after an accepted read.
module sync_fifo #(
   parameter int WIDTH     = 8,
   parameter int DEPTH     = 16,
   parameter int AF_THRESH = DEPTH - 2,
   parameter int AE_THRESH = 2
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [WIDTH-1:0]           in,
   input  logic                       wr_en,
   input  logic                       rd_en,
   input  logic                       flush,
   output logic [WIDTH-1:0]           out,
   output logic                       full,
   output logic                       empty,
   output logic                       almost_full,
   output logic                       almost_empty,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       overflow,
   output logic                       underflow
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW-1:0]    rd_ptr_nxt;
   logic             wr_acc;
   logic             rd_acc;

   // All flags come from the registered count, never from pointer comparison.
   assign full         = (count == CW'(DEPTH));
   assign empty        = (count == '0);
   assign almost_full  = (count >= CW'(AF_THRESH));
   assign almost_empty = (count <= CW'(AE_THRESH));

   assign wr_acc     = wr_en && !full && !flush && !reset;
   assign rd_acc     = rd_en && !empty && !flush && !reset;
   assign rd_ptr_nxt = rd_ptr + AW'(1);

   always_ff @(posedge clk) begin
      if (wr_acc) begin
         mem[wr_ptr] <= in;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
         out       <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_acc) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (rd_acc) begin
            rd_ptr <= rd_ptr_nxt;
         end
         count <= count + CW'(wr_acc) - CW'(rd_acc);
         if (wr_en && full) begin
            overflow <= 1'b1;
         end
         if (rd_en && empty) begin
            underflow <= 1'b1;
         end
`ifdef SYNC_FIFO_FWFT_EN
         // The head register is refilled from the incoming word when it becomes the only entry.
         if (wr_acc && (empty || (rd_acc && count == CW'(1)))) begin
            out <= in;
         end else if (rd_acc && count > CW'(1)) begin
            out <= mem[rd_ptr_nxt];
         end
`else
         if (rd_acc) begin
            out <= mem[rd_ptr];
         end
`endif
      end
   end

endmodule
